// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO buffer between several requesters,
// with a timed lock for exclusive back-to-back access and a registered pop response.
module lifo_arbiter #(
    parameter int data_width = 8,
    parameter int num_req    = 4,
    parameter int lock_max   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [num_req-1:0]               req_valid,
    input  logic [num_req-1:0]               req_push,
    input  logic [num_req-1:0]               req_lock,
    input  logic [num_req*data_width-1:0]    req_data,
    output logic [num_req-1:0]               req_ready,
    output logic                             rsp_valid,
    output logic [$clog2(num_req)-1:0]       rsp_id,
    output logic [data_width-1:0]            rsp_data,
    output logic                             lifo_push,
    output logic                             lifo_pop,
    output logic [data_width-1:0]            lifo_w_data,
    input  logic                             lifo_empty,
    input  logic                             lifo_full,
    input  logic [data_width-1:0]            lifo_r_data,
    output logic                             lock_active,
    output logic [$clog2(num_req)-1:0]       lock_owner,
    output logic                             lock_timeout
);
    localparam int IDW = $clog2(num_req);
    localparam int CW  = $clog2(lock_max);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [IDW-1:0]        lock_owner_q, lock_owner_d;
    logic                  lock_timeout_q, lock_timeout_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]        rsp_id_q, rsp_id_d;
    logic [data_width-1:0] rsp_data_q, rsp_data_d;

    logic [num_req-1:0]    elig;
    logic                  gnt_vld;
    logic [IDW-1:0]        gnt_id;
    logic                  gnt_push;
    logic                  gnt_lock;
    logic [IDW-1:0]        idx_w;
    logic [data_width-1:0] data_arr [num_req];

    // Grant selection: owner only while locked, otherwise first eligible from rr_ptr.
    always_comb begin
        elig = req_valid & ((req_push & {num_req{~lifo_full}})
                          | (~req_push & {num_req{~lifo_empty}}));
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx_w   = '0;
        if (state_q == LOCKED) begin
            gnt_vld = elig[lock_owner_q];
            gnt_id  = lock_owner_q;
        end else begin
            for (int k = num_req - 1; k >= 0; k--) begin
                idx_w = IDW'((int'(rr_ptr_q) + k) % num_req);
                if (elig[idx_w]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = idx_w;
                end
            end
        end
        gnt_push = req_push[gnt_id];
        gnt_lock = req_lock[gnt_id];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ARB;
            rr_ptr_q       <= '0;
            lock_cnt_q     <= '0;
            lock_owner_q   <= '0;
            lock_timeout_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            lock_cnt_q     <= lock_cnt_d;
            lock_owner_q   <= lock_owner_d;
            lock_timeout_q <= lock_timeout_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        lock_cnt_d     = lock_cnt_q;
        lock_owner_d   = lock_owner_q;
        lock_timeout_d = 1'b0;
        rsp_valid_d    = gnt_vld & ~gnt_push;
        rsp_id_d       = rsp_valid_d ? gnt_id : rsp_id_q;
        rsp_data_d     = rsp_valid_d ? lifo_r_data : rsp_data_q;
        unique case (state_q)
            ARB: begin
                if (gnt_vld) begin
                    rr_ptr_d = (gnt_id == IDW'(num_req - 1)) ? '0 : gnt_id + 1'b1;
                    if (gnt_lock) begin
                        state_d      = LOCKED;
                        lock_owner_d = gnt_id;
                        lock_cnt_d   = '0;
                    end
                end
            end
            LOCKED: begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (!req_lock[lock_owner_q]) begin
                    state_d      = ARB;
                    lock_owner_d = '0;
                    lock_cnt_d   = '0;
                end else if (lock_cnt_q == CW'(lock_max - 1)) begin
                    state_d        = ARB;
                    lock_timeout_d = 1'b1;
                    rr_ptr_d       = (lock_owner_q == IDW'(num_req - 1)) ?
                                     '0 : lock_owner_q + 1'b1;
                    lock_owner_d   = '0;
                    lock_cnt_d     = '0;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        for (int i = 0; i < num_req; i++) begin
            data_arr[i] = req_data[i*data_width +: data_width];
        end
        req_ready = '0;
        if (reset && gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
        lifo_push    = reset & gnt_vld & gnt_push;
        lifo_pop     = reset & gnt_vld & ~gnt_push;
        lifo_w_data  = lifo_push ? data_arr[gnt_id] : '0;
        rsp_valid    = rsp_valid_q;
        rsp_id       = rsp_id_q;
        rsp_data     = rsp_data_q;
        lock_active  = (state_q == LOCKED);
        lock_owner   = lock_owner_q;
        lock_timeout = lock_timeout_q;
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter: directed scenarios plus a randomized run against
// a queue-based stack and a rule-level arbitration model.
module tb_lifo_arbiter;
    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int LM    = 16;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid, req_push, req_lock;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            lifo_push, lifo_pop;
    logic [DW-1:0]   lifo_w_data;
    logic            lifo_empty, lifo_full;
    logic [DW-1:0]   lifo_r_data;
    logic            lock_active;
    logic [1:0]      lock_owner;
    logic            lock_timeout;

    lifo_arbiter #(.data_width(DW), .num_req(NR), .lock_max(LM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_push(req_push), .req_lock(req_lock),
        .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_w_data(lifo_w_data),
        .lifo_empty(lifo_empty), .lifo_full(lifo_full), .lifo_r_data(lifo_r_data),
        .lock_active(lock_active), .lock_owner(lock_owner),
        .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] stk[$];

    // reference model state
    int          m_rr;
    bit          m_locked;
    int          m_owner;
    int          m_held;
    int          e_gnt;
    bit          e_rsp_valid;
    int          e_rsp_id;
    logic [DW-1:0] e_rsp_data;
    bit          e_tmo;

    task automatic drive_flags();
        lifo_empty = (stk.size() == 0);
        lifo_full  = (stk.size() == DEPTH);
        if (stk.size() > 0) lifo_r_data = stk[$];
        else lifo_r_data = '0;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    function automatic logic [DW-1:0] get_data(input int i);
        return req_data[i*DW +: DW];
    endfunction

    function automatic bit elig(input int i);
        if (!req_valid[i]) return 1'b0;
        if (req_push[i]) return stk.size() < DEPTH;
        return stk.size() > 0;
    endfunction

    function automatic int model_grant();
        if (m_locked) return elig(m_owner) ? m_owner : -1;
        for (int k = 0; k < NR; k++) begin
            if (elig((m_rr + k) % NR)) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_ready();
        logic [NR-1:0] r;
        r = '0;
        if (e_gnt >= 0) r[e_gnt] = 1'b1;
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_wdata();
        if (e_gnt >= 0 && req_push[e_gnt]) return get_data(e_gnt);
        return '0;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_locked = 0; m_owner = 0; m_held = 0;
        e_gnt = -1; e_rsp_valid = 0; e_rsp_id = 0; e_rsp_data = '0; e_tmo = 0;
    endtask

    task automatic model_update(input int g);
        e_tmo = 0;
        if (g >= 0 && !req_push[g]) begin
            e_rsp_valid = 1; e_rsp_id = g; e_rsp_data = stk[$];
        end else begin
            e_rsp_valid = 0;
        end
        if (g >= 0) begin
            if (req_push[g]) stk.push_back(get_data(g));
            else void'(stk.pop_back());
        end
        if (!m_locked) begin
            if (g >= 0) begin
                m_rr = (g + 1) % NR;
                if (req_lock[g]) begin
                    m_locked = 1; m_owner = g; m_held = 0;
                end
            end
        end else begin
            m_held++;
            if (!req_lock[m_owner]) begin
                m_locked = 0;
            end else if (m_held == LM) begin
                m_locked = 0; e_tmo = 1; m_rr = (m_owner + 1) % NR;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        e_gnt = model_grant();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(e_gnt);
        #1;
        drive_flags();
    endtask

    task automatic clear_req();
        req_valid = '0; req_push = '0; req_lock = '0; req_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_req();
        model_reset();
        drive_flags();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        stk.delete();
        reset = 1'b0;
        req_valid = '1; req_push = '1; req_lock = '0; req_data = '0;
        drive_flags();
        @(posedge clk);
        #2;
        total++;
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        total++;
        if (lifo_push !== 1'b0 || lifo_pop !== 1'b0) begin
            bad++; $display("FAIL rst_lifo_ops got=%b%b exp=00", lifo_push, lifo_pop);
        end
        total++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 8'h00) begin
            bad++; $display("FAIL rst_rsp got=%b/%0d/%h exp=0/0/00", rsp_valid, rsp_id, rsp_data);
        end
        total++;
        if (lock_active !== 1'b0 || lock_owner !== 2'd0 || lock_timeout !== 1'b0) begin
            bad++; $display("FAIL rst_lock got=%b/%0d/%b exp=0/0/0", lock_active, lock_owner, lock_timeout);
        end
        do_reset();
    endtask

    task automatic test_push_rr();
        do_reset();
        stk.delete(); drive_flags();
        req_valid = '1; req_push = '1;
        for (int i = 0; i < NR; i++) set_data(i, 8'(8'h10 + i));
        for (int k = 0; k < NR; k++) begin
            settle();
            total++;
            if (req_ready !== 4'(1 << k)) begin
                bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << k));
            end
            total++;
            if (lifo_push !== 1'b1 || lifo_w_data !== 8'(8'h10 + k)) begin
                bad++; $display("FAIL rr_wdata%0d got=%b/%h exp=1/%h", k, lifo_push, lifo_w_data, 8'(8'h10 + k));
            end
            tick();
        end
        req_push = '0;
        settle();
        total++;
        if (req_ready !== 4'b0001 || lifo_pop !== 1'b1) begin
            bad++; $display("FAIL rr_wrap got=%b/%b exp=0001/1", req_ready, lifo_pop);
        end
        tick();
        clear_req();
    endtask

    task automatic test_pop_rsp();
        do_reset();
        stk.delete(); stk.push_back(8'h33); stk.push_back(8'hA1); drive_flags();
        req_valid = 4'b0100; req_push = '0;
        settle();
        total++;
        if (req_ready !== 4'b0100 || lifo_pop !== 1'b1 || lifo_push !== 1'b0) begin
            bad++; $display("FAIL pop_grant got=%b/%b%b exp=0100/01", req_ready, lifo_push, lifo_pop);
        end
        tick();
        clear_req();
        settle();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'hA1) begin
            bad++; $display("FAIL pop_rsp got=%b/%0d/%h exp=1/2/a1", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        settle();
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL pop_rsp_drop got=%b exp=0", rsp_valid); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        stk.delete();
        for (int i = 0; i < DEPTH; i++) stk.push_back(8'(8'hC0 + i));
        drive_flags();
        req_valid = 4'b0011; req_push = 4'b0001; set_data(0, 8'h55);
        settle();
        total++;
        if (req_ready !== 4'b0010 || lifo_pop !== 1'b1 || lifo_push !== 1'b0) begin
            bad++; $display("FAIL full_grant got=%b/%b%b exp=0010/01", req_ready, lifo_push, lifo_pop);
        end
        tick();
        req_valid = 4'b0001;
        settle();
        total++;
        if (req_ready !== 4'b0001 || lifo_push !== 1'b1 || lifo_w_data !== 8'h55) begin
            bad++; $display("FAIL full_release got=%b/%b/%h exp=0001/1/55", req_ready, lifo_push, lifo_w_data);
        end
        tick();
        clear_req();
    endtask

    task automatic test_lock();
        do_reset();
        stk.delete(); drive_flags();
        req_valid = 4'b1010; req_push = 4'b1010; req_lock = 4'b0010;
        set_data(1, 8'h21); set_data(3, 8'h43);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) req_lock = '0;
            settle();
            total++;
            if (req_ready !== 4'b0010) begin
                bad++; $display("FAIL lock_grant%0d got=%b exp=0010", c, req_ready);
            end
            if (c > 0) begin
                total++;
                if (lock_active !== 1'b1 || lock_owner !== 2'd1) begin
                    bad++; $display("FAIL lock_state%0d got=%b/%0d exp=1/1", c, lock_active, lock_owner);
                end
            end
            tick();
        end
        req_valid = 4'b1000;
        settle();
        total++;
        if (req_ready !== 4'b1000 || lock_active !== 1'b0 || lifo_w_data !== 8'h43) begin
            bad++; $display("FAIL lock_after got=%b/%b/%h exp=1000/0/43", req_ready, lock_active, lifo_w_data);
        end
        tick();
        clear_req();
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        do_reset();
        stk.delete(); stk.push_back(8'h77); drive_flags();
        req_valid = 4'b0011; req_push = 4'b0010; req_lock = 4'b0001;
        set_data(1, 8'h33);
        for (int c = 0; c <= 18; c++) begin
            settle();
            if (lock_timeout === 1'b1) pulses++;
            if (c == 0) begin
                total++;
                if (req_ready !== 4'b0001) begin bad++; $display("FAIL tmo_lockgrant got=%b exp=0001", req_ready); end
            end else if (c <= 16) begin
                total++;
                if (req_ready !== 4'b0000 || lock_active !== 1'b1 || lock_timeout !== 1'b0) begin
                    bad++; $display("FAIL tmo_stall%0d got=%b/%b/%b exp=0000/1/0", c, req_ready, lock_active, lock_timeout);
                end
            end else if (c == 17) begin
                total++;
                if (lock_timeout !== 1'b1 || lock_active !== 1'b0 || req_ready !== 4'b0010) begin
                    bad++; $display("FAIL tmo_pulse got=%b/%b/%b exp=1/0/0010", lock_timeout, lock_active, req_ready);
                end
                req_valid = 4'b0001;
            end else begin
                total++;
                if (lock_timeout !== 1'b0) begin bad++; $display("FAIL tmo_end got=%b exp=0", lock_timeout); end
            end
            tick();
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL tmo_count got=%0d exp=1", pulses); end
        clear_req();
    endtask

    task automatic test_reset_midop();
        do_reset();
        stk.delete(); stk.push_back(8'h5A); stk.push_back(8'h6B); drive_flags();
        req_valid = 4'b0100; req_push = '0;
        settle();
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_rsp got=%b exp=0", rsp_valid); end
        total++;
        if (req_ready !== 4'b0000 || lifo_pop !== 1'b0) begin
            bad++; $display("FAIL midrst_ops got=%b/%b exp=0000/0", req_ready, lifo_pop);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        stk.delete(); drive_flags();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_push[i]  = $urandom_range(0, 1);
                req_lock[i]  = ($urandom_range(0, 7) == 0);
                set_data(i, 8'($urandom));
            end
            if (m_locked) req_lock[m_owner] = ($urandom_range(0, 15) != 0);
            settle();
            total++;
            if (req_ready !== exp_ready()) begin
                bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready());
            end
            total++;
            if (lifo_push !== (e_gnt >= 0 && req_push[e_gnt]) ||
                lifo_pop !== (e_gnt >= 0 && !req_push[e_gnt])) begin
                bad++; $display("FAIL rnd_ops c=%0d got=%b%b gnt=%0d", c, lifo_push, lifo_pop, e_gnt);
            end
            total++;
            if (lifo_w_data !== exp_wdata()) begin
                bad++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, lifo_w_data, exp_wdata());
            end
            total++;
            if (rsp_valid !== e_rsp_valid ||
                (e_rsp_valid && (rsp_id !== 2'(e_rsp_id) || rsp_data !== e_rsp_data))) begin
                bad++; $display("FAIL rnd_rsp c=%0d got=%b/%0d/%h exp=%b/%0d/%h",
                                c, rsp_valid, rsp_id, rsp_data, e_rsp_valid, e_rsp_id, e_rsp_data);
            end
            total++;
            if (lock_active !== m_locked || lock_owner !== 2'(m_locked ? m_owner : 0) ||
                lock_timeout !== e_tmo) begin
                bad++; $display("FAIL rnd_lock c=%0d got=%b/%0d/%b exp=%b/%0d/%b",
                                c, lock_active, lock_owner, lock_timeout, m_locked, m_owner, e_tmo);
            end
            tick();
        end
        clear_req();
    endtask

    initial begin
        reset = 1'b0;
        clear_req();
        model_reset();
        drive_flags();
        test_reset();
        test_push_rr();
        test_pop_rsp();
        test_full();
        test_lock();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
